// File: rtl/avaliador_pkg.sv
// Purpose: shared types and constants for the command evaluator (FSM encoding, bus widths, score ceiling).
// Latency: n/a (declarations only).
// Backpressure: n/a.
package avaliador_pkg;

    localparam int LARG_PONTOS  = 16;
    localparam int LARG_COMBO   = 8;
    localparam int LARG_COMANDO = 4;

    localparam logic [LARG_PONTOS-1:0] PONTUACAO_MAX = 16'hFFFF;

    typedef enum logic [1:0] {
        OCIOSO    = 2'd0,
        INICIANDO = 2'd1,
        RODANDO   = 2'd2,
        FIM       = 2'd3
    } estado_t;

endpackage

// File: rtl/temporizador_de_batida.sv
// Purpose: beat counter; flags the last cycle of each beat (virada) and the open hit window.
// Latency: virada/janela_aberta are combinational from the registered counter.
// Backpressure: none; counts whenever habilitar is high, limpar restarts from 0.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   limpar          synchronous clear of the counter
//   habilitar       count enable (game running)
//   virada          high in the last cycle of a beat (counter wraps at the next edge)
//   janela_aberta   high while the counter is at or past JANELA_INICIO
module temporizador_de_batida #(
    parameter int BEAT_CYCLES   = 12500000,
    parameter int JANELA_INICIO = 2,
    parameter int CNT_W         = $clog2(BEAT_CYCLES)
) (
    input  logic clk,
    input  logic rst,
    input  logic limpar,
    input  logic habilitar,
    output logic virada,
    output logic janela_aberta
);

    localparam logic [CNT_W-1:0] ULTIMO      = CNT_W'(BEAT_CYCLES - 1);
    localparam logic [CNT_W-1:0] INICIO_JAN  = CNT_W'(JANELA_INICIO);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (limpar) begin
            cnt <= '0;
        end else if (habilitar) begin
            cnt <= virada ? '0 : cnt + 1'b1;
        end
    end

    assign virada        = habilitar && (cnt == ULTIMO);
    // The upper bound of the window is the last beat cycle, which cnt never exceeds.
    assign janela_aberta = habilitar && (cnt >= INICIO_JAN);

endmodule

// File: rtl/avaliador_de_comandos.sv
// Purpose: drives the pattern manager beat, judges button presses against the current command, keeps score/combo.
// Latency: press edge -> acerto/erro and score update 1 cycle; beat wrap -> trocar_comando 1 cycle.
// Backpressure: none; inputs are sampled every cycle, outputs are pulses/levels with no handshake.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start             begins a game from OCIOSO or FIM
//   botoes            debounced player buttons, one bit per direction
//   comando           one-hot command from the pattern manager (0 = rest)
//   fim_de_jogo       end-of-list flag from the pattern manager
//   trocar_comando    one-cycle beat pulse advancing the pattern manager
//   rst_padroes       restart request the pattern manager samples on trocar_comando
//   acerto / erro     one-cycle hit / wrong-or-miss pulses
//   pontuacao, combo, max_combo   saturating score state
//   jogo_ativo        high while a game is running
import avaliador_pkg::*;

module avaliador_de_comandos #(
    parameter int BEAT_CYCLES   = 12500000,
    parameter int JANELA_INICIO = 2,
    parameter int PONTOS_ACERTO = 10,
    parameter int COMBO_DOBRO   = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [LARG_COMANDO-1:0] botoes,
    input  logic [LARG_COMANDO-1:0] comando,
    input  logic                    fim_de_jogo,
    output logic                    trocar_comando,
    output logic                    rst_padroes,
    output logic                    acerto,
    output logic                    erro,
    output logic [LARG_PONTOS-1:0]  pontuacao,
    output logic [LARG_COMBO-1:0]   combo,
    output logic [LARG_COMBO-1:0]   max_combo,
    output logic                    jogo_ativo
);

    localparam logic [LARG_PONTOS:0]  INC_SIMPLES  = (LARG_PONTOS+1)'(PONTOS_ACERTO);
    localparam logic [LARG_PONTOS:0]  INC_DOBRO    = (LARG_PONTOS+1)'(2 * PONTOS_ACERTO);
    localparam logic [LARG_COMBO-1:0] LIMIAR_DOBRO = LARG_COMBO'(COMBO_DOBRO);
    localparam logic [LARG_COMBO-1:0] COMBO_MAX    = '1;

    estado_t estado, prox_estado;

    logic [LARG_COMANDO-1:0] botoes_q;
    logic [LARG_COMANDO-1:0] prem;
    logic                    virada, janela_aberta;
    logic                    rodando, iniciando;
    logic                    julgado, fim_pend, fim_agora;
    logic                    julgar, acertou, errou;
    logic                    trocar_d, rst_padroes_d;
    logic [LARG_PONTOS:0]    soma;
    logic [LARG_COMBO-1:0]   combo_novo;

    assign rodando   = (estado == RODANDO);
    assign iniciando = (estado == INICIANDO);

    temporizador_de_batida #(
        .BEAT_CYCLES   (BEAT_CYCLES),
        .JANELA_INICIO (JANELA_INICIO)
    ) u_temporizador (
        .clk           (clk),
        .rst           (rst),
        .limpar        (iniciando),
        .habilitar     (rodando),
        .virada        (virada),
        .janela_aberta (janela_aberta)
    );

    // Rising edges only, so a held button is judged once.
    assign prem = botoes & ~botoes_q;

    // One judgement per beat. A press in the last cycle takes priority over the miss.
    assign julgar  = rodando && janela_aberta && !julgado && (comando != '0);
    assign acertou = julgar && (prem == comando);
    assign errou   = julgar && (((prem != '0) && (prem != comando)) || (virada && (prem == '0)));

    // End flag may arrive in the wrap cycle itself, so look at the live input too.
    assign fim_agora = fim_pend || fim_de_jogo;

    assign soma       = {1'b0, pontuacao} + ((combo >= LIMIAR_DOBRO) ? INC_DOBRO : INC_SIMPLES);
    assign combo_novo = (combo == COMBO_MAX) ? combo : combo + 1'b1;

    // FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado <= OCIOSO;
        end else begin
            estado <= prox_estado;
        end
    end

    // FSM: next state
    always_comb begin
        prox_estado = estado;
        case (estado)
            OCIOSO:    if (start) prox_estado = INICIANDO;
            INICIANDO: prox_estado = RODANDO;
            RODANDO:   if (virada && fim_agora) prox_estado = FIM;
            FIM:       if (start) prox_estado = INICIANDO;
            default:   prox_estado = OCIOSO;
        endcase
    end

    // FSM: outputs. The first pulse comes from INICIANDO while rst_padroes is still
    // high, so the pattern manager restarts on it; later pulses come from beat wraps.
    always_comb begin
        trocar_d      = iniciando || (rodando && virada && !fim_agora);
        rst_padroes_d = !rodando;
        jogo_ativo    = rodando;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trocar_comando <= 1'b0;
            rst_padroes    <= 1'b1;
            botoes_q       <= '0;
        end else begin
            trocar_comando <= trocar_d;
            rst_padroes    <= rst_padroes_d;
            botoes_q       <= botoes;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            julgado  <= 1'b0;
            fim_pend <= 1'b0;
        end else begin
            if (iniciando || virada) begin
                julgado <= 1'b0;
            end else if (acertou || errou) begin
                julgado <= 1'b1;
            end

            if (iniciando) begin
                fim_pend <= 1'b0;
            end else if (rodando && fim_de_jogo) begin
                fim_pend <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acerto    <= 1'b0;
            erro      <= 1'b0;
            pontuacao <= '0;
            combo     <= '0;
            max_combo <= '0;
        end else begin
            acerto <= acertou;
            erro   <= errou;
            if (iniciando) begin
                pontuacao <= '0;
                combo     <= '0;
                max_combo <= '0;
            end else if (acertou) begin
                pontuacao <= soma[LARG_PONTOS] ? PONTUACAO_MAX : soma[LARG_PONTOS-1:0];
                combo     <= combo_novo;
                if (combo_novo > max_combo) begin
                    max_combo <= combo_novo;
                end
            end else if (errou) begin
                combo <= '0;
            end
        end
    end

endmodule

// File: tb/tb_avaliador_de_comandos.sv
// Purpose: self-checking bench for avaliador_de_comandos with a beat-level reference model and event scoreboard.
// Latency: expects acerto/erro one cycle after the judged press (or after the last beat cycle for a miss).
// Backpressure: n/a.
module tb_avaliador_de_comandos;

    localparam int BC = 16;
    localparam int JI = 2;
    localparam int PA = 10;
    localparam int CD = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  botoes;
    logic [3:0]  comando;
    logic        fim_de_jogo;
    logic        trocar_comando;
    logic        rst_padroes;
    logic        acerto;
    logic        erro;
    logic [15:0] pontuacao;
    logic [7:0]  combo;
    logic [7:0]  max_combo;
    logic        jogo_ativo;

    always #5 clk = ~clk;

    avaliador_de_comandos #(
        .BEAT_CYCLES   (BC),
        .JANELA_INICIO (JI),
        .PONTOS_ACERTO (PA),
        .COMBO_DOBRO   (CD)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .botoes         (botoes),
        .comando        (comando),
        .fim_de_jogo    (fim_de_jogo),
        .trocar_comando (trocar_comando),
        .rst_padroes    (rst_padroes),
        .acerto         (acerto),
        .erro           (erro),
        .pontuacao      (pontuacao),
        .combo          (combo),
        .max_combo      (max_combo),
        .jogo_ativo     (jogo_ativo)
    );

    typedef struct {
        logic [1:0] tipo;   // {acerto, erro}
        int         ciclo;
        int         pont;
        int         comb;
        int         maxc;
    } esperado_t;

    esperado_t fila[$];

    int erros  = 0;
    int checks = 0;
    int ncyc   = 0;
    int m_pont = 0;
    int m_combo = 0;
    int m_max  = 0;

    task automatic verificar(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        checks++;
        if (obs !== esp) begin
            erros++;
            $display("FAIL %s: observado=%0h esperado=%0h (ciclo %0d)", tag, obs, esp, ncyc);
        end
    endtask

    task automatic monitorar();
        esperado_t e;
        if (acerto || erro) begin
            verificar("exclusivo", 32'(acerto & erro), 0);
            if (fila.size() == 0) begin
                verificar("evento_inesperado", 32'({acerto, erro}), 0);
            end else begin
                e = fila.pop_front();
                verificar("tipo",      32'({acerto, erro}), 32'(e.tipo));
                verificar("ciclo",     ncyc,                e.ciclo);
                verificar("pontuacao", 32'(pontuacao),      e.pont);
                verificar("combo",     32'(combo),          e.comb);
                verificar("max_combo", 32'(max_combo),      e.maxc);
            end
        end
    endtask

    task automatic ciclo();
        @(negedge clk);
        ncyc++;
        monitorar();
    endtask

    // Reference model update for one judgement; the DUT shows it one cycle later.
    task automatic prever(input bit hit);
        esperado_t e;
        int inc;
        if (hit) begin
            inc     = (m_combo >= CD) ? 2 * PA : PA;
            m_pont  = (m_pont + inc > 65535) ? 65535 : m_pont + inc;
            m_combo = (m_combo == 255) ? 255 : m_combo + 1;
            if (m_combo > m_max) m_max = m_combo;
            e.tipo = 2'b10;
        end else begin
            m_combo = 0;
            e.tipo  = 2'b01;
        end
        e.ciclo = ncyc + 1;
        e.pont  = m_pont;
        e.comb  = m_combo;
        e.maxc  = m_max;
        fila.push_back(e);
    endtask

    // Entered at the negedge of a beat's cnt=0 cycle; leaves at the next beat's cnt=0 cycle.
    task automatic batida(input logic [3:0] cmd, input int p1, input logic [3:0] v1,
                          input int p2, input logic [3:0] v2, input bit fim);
        logic [3:0] b, prev, pr;
        bit julg;
        comando = cmd;
        prev    = botoes;
        julg    = 1'b0;
        for (int k = 0; k < BC; k++) begin
            b      = (k == p1) ? v1 : ((k == p2) ? v2 : 4'b0000);
            botoes = b;
            pr     = b & ~prev;
            prev   = b;
            if (fim && k == 3) fim_de_jogo = 1'b1;
            if (k == 8) begin
                verificar("trocar_meio_batida", 32'(trocar_comando), 0);
                verificar("jogo_ativo",         32'(jogo_ativo),     1);
            end
            if (cmd != 4'b0000 && !julg && k >= JI && pr != 4'b0000) begin
                julg = 1'b1;
                prever(pr == cmd);
            end else if (cmd != 4'b0000 && !julg && k == BC - 1) begin
                julg = 1'b1;
                prever(1'b0);
            end
            ciclo();
        end
        botoes = 4'b0000;
    endtask

    task automatic batida_e_troca(input logic [3:0] cmd, input int p1, input logic [3:0] v1,
                                  input int p2, input logic [3:0] v2);
        batida(cmd, p1, v1, p2, v2, 1'b0);
        verificar("trocar_batida",   32'(trocar_comando), 1);
        verificar("rst_padroes_run", 32'(rst_padroes),    0);
    endtask

    task automatic aguardar_troca();
        bit visto;
        visto = 1'b0;
        for (int i = 0; i < 20 && !visto; i++) begin
            ciclo();
            if (trocar_comando) visto = 1'b1;
        end
        verificar("timeout_trocar", 32'(visto), 1);
    endtask

    initial begin
        rst         = 1'b1;
        start       = 1'b0;
        botoes      = 4'b0000;
        comando     = 4'b0000;
        fim_de_jogo = 1'b0;

        ciclo();
        verificar("reset_trocar",      32'(trocar_comando), 0);
        verificar("reset_rst_padroes", 32'(rst_padroes),    1);
        verificar("reset_acerto",      32'(acerto),         0);
        verificar("reset_erro",        32'(erro),           0);
        verificar("reset_pontuacao",   32'(pontuacao),      0);
        verificar("reset_combo",       32'(combo),          0);
        verificar("reset_max_combo",   32'(max_combo),      0);
        verificar("reset_jogo_ativo",  32'(jogo_ativo),     0);

        rst = 1'b0;
        ciclo();
        ciclo();
        verificar("ocioso_trocar", 32'(trocar_comando), 0);

        // First game: the opening pulse carries rst_padroes=1.
        start = 1'b1;
        ciclo();
        start = 1'b0;
        aguardar_troca();
        verificar("primeira_troca_rst", 32'(rst_padroes), 1);
        verificar("inicio_jogo_ativo",  32'(jogo_ativo),  1);

        batida_e_troca(4'b0100, 5, 4'b0100, 9, 4'b0100);    // hit; second press ignored
        start = 1'b1;                                      // ignored while running
        batida_e_troca(4'b0001, 4, 4'b0001, -1, 4'b0000);  // hit
        start = 1'b0;
        batida_e_troca(4'b1000, 7, 4'b1000, -1, 4'b0000);  // doubled hit
        batida_e_troca(4'b0001, 6, 4'b0010, -1, 4'b0000);  // wrong button
        batida_e_troca(4'b1000, -1, 4'b0000, -1, 4'b0000); // miss
        batida_e_troca(4'b0010, 1, 4'b0010, -1, 4'b0000);  // press before window, then miss
        batida_e_troca(4'b0010, 15, 4'b0010, -1, 4'b0000); // press in last cycle
        batida_e_troca(4'b0000, 5, 4'b0100, -1, 4'b0000);  // rest beat
        batida_e_troca(4'b0100, 3, 4'b0110, -1, 4'b0000);  // multi-button press
        batida(4'b0001, 15, 4'b0001, -1, 4'b0000, 1'b1);   // last beat, final-cycle hit
        fim_de_jogo = 1'b0;
        verificar("fim_sem_trocar", 32'(trocar_comando), 0);
        verificar("fim_jogo_ativo", 32'(jogo_ativo),     0);
        for (int i = 0; i < 20; i++) begin
            ciclo();
            verificar("fim_parado", 32'(trocar_comando), 0);
        end
        verificar("fim_rst_padroes", 32'(rst_padroes), 1);
        verificar("fim_pontuacao",   32'(pontuacao),   m_pont);
        verificar("fim_combo",       32'(combo),       m_combo);
        verificar("fim_max_combo",   32'(max_combo),   m_max);
        verificar("fim_fila_vazia",  fila.size(),      0);

        // Second game from FIM clears the score.
        start = 1'b1;
        ciclo();
        start = 1'b0;
        m_pont  = 0;
        m_combo = 0;
        m_max   = 0;
        aguardar_troca();
        verificar("reinicio_rst",       32'(rst_padroes), 1);
        verificar("reinicio_pontuacao", 32'(pontuacao),   0);
        verificar("reinicio_max_combo", 32'(max_combo),   0);
        batida_e_troca(4'b0100, 5, 4'b0100, -1, 4'b0000);

        // Asynchronous abort mid-beat.
        ciclo();
        ciclo();
        ciclo();
        rst = 1'b1;
        #1;
        verificar("abort_trocar",      32'(trocar_comando), 0);
        verificar("abort_rst_padroes", 32'(rst_padroes),    1);
        verificar("abort_pontuacao",   32'(pontuacao),      0);
        verificar("abort_combo",       32'(combo),          0);
        verificar("abort_max_combo",   32'(max_combo),      0);
        verificar("abort_jogo_ativo",  32'(jogo_ativo),     0);
        verificar("abort_acerto_erro", 32'({acerto, erro}), 0);
        verificar("abort_fila_vazia",  fila.size(),         0);

        $display("Result: errors=%0d of %0d checks", erros, checks);
        $finish;
    end

endmodule
